fft_input_pingpong: RTL
=======================

Name: fft_input_pingpong

Overview:
- Parametrised successor of the single-buffer FFT input controller. Accepts complex samples over AXI4-Stream and writes them in bit-reversed (or natural) order into one of two ping-pong banks.
- While the FFT core reads one full bank through two random-access read ports, the next frame loads into the other bank.
- Sits between the AXIS DMA/source and the FFT butterfly core. Adds tlast framing checks and back-pressure.

Parameters:
- DATA_W, 64, sample width ({imag, real}); must be even.
- LOG2N, 8, log2 of frame length; N = 2**LOG2N points per frame, per bank.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tvalid  in  1  AXIS sample valid.
- s_axis_tdata  in  DATA_W  AXIS sample.
- s_axis_tlast  in  1  AXIS end-of-frame marker.
- s_axis_tready  out  1  AXIS ready.
- bitrev_en  in  1  1 = bit-reversed write address; 0 = natural order.
- frame_valid  out  1  at least one full bank is available to the core.
- frame_done  in  1  core pulse: finished with current read bank, release it.
- rd_addr_a  in  LOG2N  read address, port A.
- rd_addr_b  in  LOG2N  read address, port B.
- rd_data_a  out  DATA_W  data at rd_addr_a of the current read bank.
- rd_data_b  out  DATA_W  data at rd_addr_b of the current read bank.
- load_done  out  1  1-cycle pulse: a frame was committed to a bank.
- tlast_err  out  1  1-cycle pulse: framing error detected.

Behaviour:
- Reset (rst=1 at posedge): wr_cnt=0, wr_bank=0, rd_bank=0, full_cnt=0. s_axis_tready, frame_valid, load_done, tlast_err and rd_data_a/b all 0. Reset mid-frame discards the partial frame and any full banks.
- Bank state: full_cnt in {0,1,2}.
  - s_axis_tready = !rst_q && (full_cnt < 2), registered, where rst_q is the reset state. tready is 0 in the cycle reset is applied and rises the cycle after reset deasserts, if full_cnt < 2.
  - frame_valid = (full_cnt != 0).
- Accept = s_axis_tvalid && s_axis_tready. On accept:
  - Write s_axis_tdata to bank wr_bank.
  - Write address = bit-reverse of wr_cnt over LOG2N bits (bit i -> bit LOG2N-1-i) when the latched mode is 1; otherwise wr_cnt.
  - bitrev_en is latched on the first beat of a frame (wr_cnt==0) and that latched value applies for the whole frame. The first beat itself uses the live value.
- Frame end, beat with wr_cnt==N-1 accepted:
  - Set wr_cnt=0, toggle wr_bank, increment full_cnt.
  - Next cycle: load_done=1.
  - If tlast=0 on that beat, tlast_err=1 in the same next cycle; the frame is still committed.
- Early tlast, tlast=1 on a beat with wr_cnt<N-1:
  - The beat is written, the frame is discarded: wr_cnt=0, wr_bank and full_cnt unchanged.
  - Next cycle: tlast_err=1, load_done=0.
- Release:
  - frame_done=1 while frame_valid=1: toggle rd_bank, decrement full_cnt.
  - frame_done while frame_valid=0 is ignored.
- Simultaneous commit and release in the same cycle: full_cnt unchanged; wr_bank and rd_bank both toggle.
- tready update after a commit: when full_cnt reaches 2, s_axis_tready drops on the cycle after the committing beat. No beat is accepted into a full bank.
- Reads:
  - Synchronous, 1-cycle latency: rd_data_x at edge k+1 reflects rd_addr_x sampled at edge k from rd_bank at edge k.
  - Both ports may address the same location.
  - Reads are not meaningful while frame_valid=0; data is undefined but must not be X after the first frame.
- Storage: two banks of N x DATA_W. Each bank has one write port and two read ports; implement as two dual-port RAMs per bank or equivalent.
- wr_cnt wraps only via the frame-end and early-tlast rules above; no other wrap.

Test Plan:
- Reset, then N=256 samples with data=index, tlast on beat 255, bitrev_en=1:
  - load_done pulses once and frame_valid=1.
  - rd_addr_a=1 returns 128; rd_addr_a=3 returns 192; rd_addr_b=255 returns 255, each 1 cycle after the address.
- Same frame with bitrev_en=0: rd_addr_a=k returns k for all k. Toggle bitrev_en mid-frame: mapping is unchanged for that frame.
- Three back-to-back frames with no frame_done:
  - full_cnt reaches 2 after frame 2; tready=0 and frame 3 stalls.
  - Pulse frame_done: tready returns, frame 3 loads into bank 0.
  - Reads then show frame 2 data.
- tlast on beat 99 of a frame:
  - tlast_err pulses, no load_done, frame_valid unchanged.
  - Next 256-beat frame commits normally to the same bank.
- No tlast on beat 255: load_done and tlast_err pulse together; frame is readable.
- Commit and frame_done in the same cycle with full_cnt=1: full_cnt stays 1 and rd_bank toggles. Assert rst mid-frame: tready=0, frame_valid=0, next frame starts at wr_cnt=0.

Source files
------------

// File: rtl/fft_input_pingpong_if.sv
// FFT input ping-pong interface: AXIS sample ingress, frame handshake and
// dual random-access read ports between the loader and the FFT core.
// Carries no logic; the slave modport is the loader, the master modport the environment.
interface fft_input_pingpong_if #(
  parameter int DATA_W = 64,
  parameter int LOG2N  = 8
);
  logic              s_axis_tvalid;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              bitrev_en;
  logic              frame_valid;
  logic              frame_done;
  logic [LOG2N-1:0]  rd_addr_a;
  logic [LOG2N-1:0]  rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              load_done;
  logic              tlast_err;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, bitrev_en,
    input  frame_done, rd_addr_a, rd_addr_b,
    output s_axis_tready, frame_valid, rd_data_a, rd_data_b, load_done, tlast_err
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, bitrev_en,
    output frame_done, rd_addr_a, rd_addr_b,
    input  s_axis_tready, frame_valid, rd_data_a, rd_data_b, load_done, tlast_err
  );
endinterface

// File: rtl/fft_input_pingpong.sv
// Ping-pong FFT input loader: AXIS samples written (bit-reversed or natural) into one of two banks.
// Latency: write commits on the last beat's edge; reads return 1 cycle after the address.
// Backpressure: s_axis_tready drops the cycle after both banks become full, rises once one is released.
module fft_input_pingpong #(
  parameter int DATA_W = 64,
  parameter int LOG2N  = 8
) (
  input logic                clk,
  input logic                rst,
  fft_input_pingpong_if.slave bus
);

  localparam logic [LOG2N-1:0] CNT_MAX = '1;

  logic [LOG2N-1:0]  r_wr_cnt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full_cnt;
  logic              r_tready;
  logic              r_load_done;
  logic              r_tlast_err;
  logic              r_bitrev_lat;
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;

  logic [DATA_W-1:0] r_mem0 [0:(1<<LOG2N)-1];
  logic [DATA_W-1:0] r_mem1 [0:(1<<LOG2N)-1];

  logic              w_accept;
  logic              w_last_beat;
  logic              w_commit;
  logic              w_early;
  logic              w_release;
  logic              w_mode;
  logic [LOG2N-1:0]  w_bitrev;
  logic [LOG2N-1:0]  w_wr_addr;
  logic [1:0]        w_full_nxt;

  assign w_accept    = bus.s_axis_tvalid && r_tready;
  assign w_last_beat = (r_wr_cnt == CNT_MAX);
  assign w_commit    = w_accept && w_last_beat;
  assign w_early     = w_accept && bus.s_axis_tlast && !w_last_beat;
  assign w_release   = bus.frame_done && (r_full_cnt != 2'd0);
  // First beat of a frame follows the live mode pin; the rest follow the latched copy.
  assign w_mode      = (r_wr_cnt == '0) ? bus.bitrev_en : r_bitrev_lat;
  assign w_wr_addr   = w_mode ? w_bitrev : r_wr_cnt;

  // Mirror the write counter bits to form the bit-reversed address.
  always_comb begin
    w_bitrev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_bitrev[i] = r_wr_cnt[LOG2N-1-i];
    end
  end

  // Occupancy after this cycle's commit and release; both together cancel out.
  always_comb begin
    w_full_nxt = r_full_cnt;
    if (w_commit && !w_release) begin
      w_full_nxt = r_full_cnt + 2'd1;
    end else if (!w_commit && w_release) begin
      w_full_nxt = r_full_cnt - 2'd1;
    end
  end

  // Frame control: write counter, bank pointers, occupancy, ready and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt     <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_full_cnt   <= 2'd0;
      r_tready     <= 1'b0;
      r_load_done  <= 1'b0;
      r_tlast_err  <= 1'b0;
      r_bitrev_lat <= 1'b0;
    end else begin
      r_full_cnt  <= w_full_nxt;
      r_tready    <= (w_full_nxt != 2'd2);
      r_load_done <= w_commit;
      r_tlast_err <= (w_commit && !bus.s_axis_tlast) || w_early;
      if (w_commit) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_early) begin
        r_wr_cnt  <= '0;
      end else if (w_accept) begin
        r_wr_cnt  <= r_wr_cnt + 1'b1;
      end
      if (w_accept && (r_wr_cnt == '0)) begin
        r_bitrev_lat <= bus.bitrev_en;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Sample storage write port; banks hold no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_wr_bank) begin
        r_mem1[w_wr_addr] <= bus.s_axis_tdata;
      end else begin
        r_mem0[w_wr_addr] <= bus.s_axis_tdata;
      end
    end
  end

  // Registered read ports from the bank currently owned by the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
    end else begin
      r_rd_data_a <= r_rd_bank ? r_mem1[bus.rd_addr_a] : r_mem0[bus.rd_addr_a];
      r_rd_data_b <= r_rd_bank ? r_mem1[bus.rd_addr_b] : r_mem0[bus.rd_addr_b];
    end
  end

  assign bus.s_axis_tready = r_tready;
  assign bus.frame_valid   = (r_full_cnt != 2'd0);
  assign bus.load_done     = r_load_done;
  assign bus.tlast_err     = r_tlast_err;
  assign bus.rd_data_a     = r_rd_data_a;
  assign bus.rd_data_b     = r_rd_data_b;

endmodule
